// File: rtl/csr_file.sv
// CSR file: generic scratch registers plus 64-bit mcycle/minstret counters and their
// read-only shadows, behind a one-deep request/response handshake.
module csr_file #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_SCRATCH  = 1,
  parameter logic [11:0] SCRATCH_BASE = 12'h340
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [11:0]     req_addr,
  input  logic [1:0]      req_write_func,
  input  logic            req_input_sel,
  input  logic            req_read_enable,
  input  logic            req_write_enable,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [4:0]      req_uimm,
  input  logic            retire,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal
);

  localparam logic [1:0] WF_NONE = 2'd0;
  localparam logic [1:0] WF_RW   = 2'd1;
  localparam logic [1:0] WF_RS   = 2'd2;
  localparam logic [1:0] WF_RC   = 2'd3;
  // High counter halves only exist as separate CSRs on a 32-bit datapath.
  localparam bit HAS_HI = (XLEN == 32);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] scratch_q [NUM_SCRATCH];
  logic [XLEN-1:0] scratch_d [NUM_SCRATCH];
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_illegal_q, resp_illegal_d;

  logic [11:0]     scr_off;
  logic            scr_hit;
  logic            addr_ok;
  logic            sel_mc_lo, sel_mc_hi, sel_mi_lo, sel_mi_hi;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;
  logic            illegal;
  logic            accept;
  logic            do_write;

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;
  assign accept       = req_valid && req_ready;

  // Address decode and pre-write value of the addressed CSR.
  always_comb begin
    scr_off   = req_addr - SCRATCH_BASE;
    scr_hit   = (scr_off < 12'(NUM_SCRATCH));
    addr_ok   = 1'b0;
    old_val   = '0;
    sel_mc_lo = 1'b0;
    sel_mc_hi = 1'b0;
    sel_mi_lo = 1'b0;
    sel_mi_hi = 1'b0;
    if (scr_hit) begin
      addr_ok = 1'b1;
      for (int unsigned k = 0; k < NUM_SCRATCH; k++) begin
        if (scr_off == 12'(k)) old_val = scratch_q[k];
      end
    end else begin
      case (req_addr)
        12'hB00, 12'hC00: begin
          addr_ok   = 1'b1;
          sel_mc_lo = 1'b1;
          old_val   = XLEN'(mcycle_q);
        end
        12'hB80, 12'hC80: begin
          addr_ok   = HAS_HI;
          sel_mc_hi = 1'b1;
          old_val   = XLEN'(mcycle_q[63:32]);
        end
        12'hB02, 12'hC02: begin
          addr_ok   = 1'b1;
          sel_mi_lo = 1'b1;
          old_val   = XLEN'(minstret_q);
        end
        12'hB82, 12'hC82: begin
          addr_ok   = HAS_HI;
          sel_mi_hi = 1'b1;
          old_val   = XLEN'(minstret_q[63:32]);
        end
        default: addr_ok = 1'b0;
      endcase
    end
  end

  // Legality, operand selection and read-modify-write result.
  always_comb begin
    illegal = !addr_ok
           || (req_write_enable && (req_addr[11:10] == 2'b11))
           || (req_write_func == WF_NONE);
    operand = req_input_sel ? XLEN'(req_uimm) : req_rs1_data;
    case (req_write_func)
      WF_RW:   new_val = operand;
      WF_RS:   new_val = old_val | operand;
      WF_RC:   new_val = old_val & ~operand;
      default: new_val = old_val;
    endcase
    do_write = accept && req_write_enable && !illegal;
  end

  // Next state: handshake FSM, response capture, CSR updates and counters.
  always_comb begin
    state_d        = state_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;
    scratch_d      = scratch_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + 64'(retire);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d        = RESP;
          resp_illegal_d = illegal;
          resp_rdata_d   = (req_read_enable && !illegal) ? old_val : '0;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
    endcase

    // A written counter half wins over the increment; the other half holds.
    if (do_write) begin
      for (int unsigned k = 0; k < NUM_SCRATCH; k++) begin
        if (scr_hit && (scr_off == 12'(k))) scratch_d[k] = new_val;
      end
      if (sel_mc_lo) begin
        mcycle_d            = mcycle_q;
        mcycle_d[XLEN-1:0]  = new_val;
      end
      if (sel_mc_hi) begin
        mcycle_d            = mcycle_q;
        mcycle_d[63:32]     = new_val[31:0];
      end
      if (sel_mi_lo) begin
        minstret_d           = minstret_q;
        minstret_d[XLEN-1:0] = new_val;
      end
      if (sel_mi_hi) begin
        minstret_d           = minstret_q;
        minstret_d[63:32]    = new_val[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      resp_rdata_q   <= '0;
      resp_illegal_q <= 1'b0;
      scratch_q      <= '{default: '0};
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      state_q        <= state_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
      scratch_q      <= scratch_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios plus randomized accesses checked against a
// transaction-level model of the CSR space and free-running counters.
module tb_csr_file;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NS   = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            req_valid;
  logic            req_ready;
  logic [11:0]     req_addr;
  logic [1:0]      req_write_func;
  logic            req_input_sel;
  logic            req_read_enable;
  logic            req_write_enable;
  logic [XLEN-1:0] req_rs1_data;
  logic [4:0]      req_uimm;
  logic            retire;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_scr [NS];
  logic [63:0] m_mcycle;
  logic [63:0] m_minstret;
  bit          m_skip_mc;
  bit          m_skip_mi;

  csr_file #(.XLEN(XLEN), .NUM_SCRATCH(NS), .SCRATCH_BASE(12'h340)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_write_func   (req_write_func),
    .req_input_sel    (req_input_sel),
    .req_read_enable  (req_read_enable),
    .req_write_enable (req_write_enable),
    .req_rs1_data     (req_rs1_data),
    .req_uimm         (req_uimm),
    .retire           (retire),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_illegal     (resp_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
    m_mcycle   = '0;
    m_minstret = '0;
    m_skip_mc  = 1'b0;
    m_skip_mi  = 1'b0;
  endtask

  // One clock edge: counters advance unless a CSR write claimed them this edge.
  task automatic edge_adv();
    retire = 1'($urandom_range(0, 1));
    if (!m_skip_mc) m_mcycle = m_mcycle + 64'd1;
    if (!m_skip_mi && retire) m_minstret = m_minstret + 64'd1;
    m_skip_mc = 1'b0;
    m_skip_mi = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one accepted access on the model.
  task automatic model_access(input logic [11:0] a, input logic [1:0] f, input logic sel,
                              input logic rd, input logic wr, input logic [31:0] rs1,
                              input logic [4:0] u, output logic ill, output logic [31:0] rdat);
    logic [31:0] old, op, nv;
    int          kind;
    int          idx;
    ill  = 1'b0;
    old  = '0;
    kind = -1;
    idx  = int'(a) - 'h340;
    if (idx >= 0 && idx < NS) begin
      kind = 0;
      old  = m_scr[idx];
    end else if (a == 12'hB00 || a == 12'hC00) begin kind = 1; old = m_mcycle[31:0];
    end else if (a == 12'hB80 || a == 12'hC80) begin kind = 2; old = m_mcycle[63:32];
    end else if (a == 12'hB02 || a == 12'hC02) begin kind = 3; old = m_minstret[31:0];
    end else if (a == 12'hB82 || a == 12'hC82) begin kind = 4; old = m_minstret[63:32];
    end else ill = 1'b1;
    if (wr && a >= 12'hC00) ill = 1'b1;
    if (f == 2'd0) ill = 1'b1;
    op = sel ? {27'd0, u} : rs1;
    case (f)
      2'd1:    nv = op;
      2'd2:    nv = old | op;
      2'd3:    nv = old & ~op;
      default: nv = old;
    endcase
    rdat = (rd && !ill) ? old : 32'd0;
    if (wr && !ill) begin
      case (kind)
        0: m_scr[idx] = nv;
        1: begin m_mcycle[31:0]    = nv; m_skip_mc = 1'b1; end
        2: begin m_mcycle[63:32]   = nv; m_skip_mc = 1'b1; end
        3: begin m_minstret[31:0]  = nv; m_skip_mi = 1'b1; end
        4: begin m_minstret[63:32] = nv; m_skip_mi = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic csr_op(input logic [11:0] a, input logic [1:0] f, input logic sel,
                        input logic rd, input logic wr, input logic [31:0] rs1,
                        input logic [4:0] u, input int hold,
                        output logic [31:0] o_rdata, output logic o_ill);
    logic        exp_ill;
    logic [31:0] exp_rd;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid        = 1'b1;
    req_addr         = a;
    req_write_func   = f;
    req_input_sel    = sel;
    req_read_enable  = rd;
    req_write_enable = wr;
    req_rs1_data     = rs1;
    req_uimm         = u;
    model_access(a, f, sel, rd, wr, rs1, u, exp_ill, exp_rd);
    edge_adv();
    req_valid    = 1'b0;
    req_rs1_data = $urandom;
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("resp_rdata", 64'(resp_rdata), 64'(exp_rd));
    chk("resp_illegal", 64'(resp_illegal), 64'(exp_ill));
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    o_rdata = resp_rdata;
    o_ill   = resp_illegal;
    for (int h = 0; h < hold; h++) begin
      edge_adv();
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", 64'(resp_rdata), 64'(exp_rd));
      chk("hold_illegal", 64'(resp_illegal), 64'(exp_ill));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    edge_adv();
    resp_ready = 1'b0;
    chk("resp_done", 64'(resp_valid), 64'd0);
  endtask

  logic [11:0] pool [16] = '{12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h33F,
                             12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                             12'hC02, 12'hC82, 12'h7FF, 12'hB01};

  initial begin
    logic [31:0] rd;
    logic        il;
    logic        e_ill;
    logic [31:0] e_rd;

    reset_n          = 1'b0;
    req_valid        = 1'b0;
    req_addr         = '0;
    req_write_func   = '0;
    req_input_sel    = 1'b0;
    req_read_enable  = 1'b0;
    req_write_enable = 1'b0;
    req_rs1_data     = '0;
    req_uimm         = '0;
    retire           = 1'b0;
    resp_ready       = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_illegal", 64'(resp_illegal), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    reset_n = 1'b1;

    // Scratch read-modify-write sequence.
    csr_op(12'h340, 2'd1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 5'd0, 0, rd, il);
    chk("rw_first_old", 64'(rd), 64'h0);
    csr_op(12'h340, 2'd2, 1'b1, 1'b1, 1'b1, 32'h0, 5'd5, 0, rd, il);
    chk("rs_uimm_old", 64'(rd), 64'hDEADBEEF);
    csr_op(12'h340, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    chk("rs_uimm_new", 64'(rd), 64'hDEADBEEF);
    csr_op(12'h340, 2'd3, 1'b0, 1'b1, 1'b1, 32'h0000FFFF, 5'd0, 0, rd, il);
    csr_op(12'h340, 2'd2, 1'b0, 1'b1, 1'b1, 32'h0, 5'd0, 0, rd, il);
    chk("rc_result", 64'(rd), 64'hDEAD0000);
    csr_op(12'h340, 2'd2, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 5'd0, 0, rd, il);
    csr_op(12'h340, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    chk("rs_no_wr_en", 64'(rd), 64'hDEAD0000);

    // Illegal accesses leave state untouched.
    csr_op(12'hC00, 2'd1, 1'b0, 1'b1, 1'b1, 32'h12345678, 5'd0, 0, rd, il);
    chk("wr_shadow_ill", 64'(il), 64'd1);
    chk("wr_shadow_rdata", 64'(rd), 64'd0);
    csr_op(12'hB00, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    csr_op(12'h7FF, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    chk("unimpl_ill", 64'(il), 64'd1);
    csr_op(12'h344, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    chk("scratch_past_end_ill", 64'(il), 64'd1);
    csr_op(12'h343, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    chk("func_none_ill", 64'(il), 64'd1);

    // Carry from a written low half into the high half.
    csr_op(12'hB00, 2'd1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd0, 0, rd, il);
    csr_op(12'hB80, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    chk("mcycle_carry", 64'(rd), 64'h1);

    // Full 64-bit wrap of mcycle.
    csr_op(12'hB80, 2'd1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd0, 0, rd, il);
    csr_op(12'hB00, 2'd1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd0, 0, rd, il);
    csr_op(12'hB80, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    chk("mcycle_wrap_hi", 64'(rd), 64'h0);
    csr_op(12'hC00, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);

    // Back-pressure with retire activity continuing.
    csr_op(12'hB02, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 5, rd, il);
    csr_op(12'hC02, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);

    // Randomized accesses.
    for (int n = 0; n < 300; n++) begin
      csr_op(pool[$urandom_range(0, 15)], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             5'($urandom_range(0, 31)), int'($urandom_range(0, 2)), rd, il);
    end

    // Reset while a response is pending.
    req_valid        = 1'b1;
    req_addr         = 12'h341;
    req_write_func   = 2'd1;
    req_input_sel    = 1'b0;
    req_read_enable  = 1'b1;
    req_write_enable = 1'b1;
    req_rs1_data     = 32'hA5A5A5A5;
    model_access(12'h341, 2'd1, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 5'd0, e_ill, e_rd);
    edge_adv();
    req_valid = 1'b0;
    chk("pre_rst_valid", 64'(resp_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    retire  = 1'b0;
    #1;
    chk("async_rst_valid", 64'(resp_valid), 64'd0);
    chk("async_rst_rdata", 64'(resp_rdata), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd1);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    edge_adv();
    chk("no_replay", 64'(resp_valid), 64'd0);
    csr_op(12'hB00, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    chk("mcycle_restart", 64'(rd), 64'd1);
    csr_op(12'h341, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 0, rd, il);
    chk("scratch_cleared", 64'(rd), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of CSR reads and writes.
REQ-002 SHALL have parameter NUM_SCRATCH, default 1, number of generic read/write scratch CSRs (range 1..16).
REQ-003 SHALL have parameter SCRATCH_BASE, default 12'h340, address of scratch CSR 0; scratch k at SCRATCH_BASE+k.
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  in  1  CSR request present.
REQ-007 SHALL have port req_ready  out  1  block accepts request this cycle.
REQ-008 SHALL have port req_addr  in  12  CSR address.
REQ-009 SHALL have port req_write_func  in  2  csr_write_func: NONE=0, RW=1, RS=2, RC=3.
REQ-010 SHALL have port req_input_sel  in  1  0 = req_rs1_data operand, 1 = zero-extended req_uimm operand.
REQ-011 SHALL have port req_read_enable / req_write_enable  in  1 each  decoded read/write qualifiers.
REQ-012 SHALL have port req_rs1_data  in  XLEN  register operand.
REQ-013 SHALL have port req_uimm  in  5  immediate operand.
REQ-014 SHALL have port retire  in  1  one-cycle pulse per retired instruction.
REQ-015 SHALL have port resp_valid  out  1  response present.
REQ-016 SHALL have port resp_ready  in  1  consumer takes response.
REQ-017 SHALL have port resp_rdata  out  XLEN  old CSR value (0 if read disabled or illegal).
REQ-018 SHALL have port resp_illegal  out  1  access was illegal.

Function
REQ-019 SHALL implement a two-state FSM: IDLE, RESP; req_ready = (state==IDLE).
REQ-020 SHALL accept a request on req_valid & req_ready; next state RESP; response registered, visible the cycle after acceptance (latency 1).
REQ-021 SHALL hold resp_valid, resp_rdata and resp_illegal stable in RESP until resp_valid & resp_ready, then return to IDLE; no new acceptance in that same cycle.
REQ-022 SHALL implement: scratch[NUM_SCRATCH]; mcycle 64-bit at 0xB00 (low) / 0xB80 (high); minstret 64-bit at 0xB02 / 0xB82; read-only shadows cycle 0xC00/0xC80, instret 0xC02/0xC82.
REQ-023 SHALL flag illegal when address is unimplemented, or req_write_enable=1 with req_addr[11:10]==2'b11, or req_write_func==NONE.
REQ-024 SHALL on illegal: no CSR modified, resp_illegal=1, resp_rdata=0.
REQ-025 SHALL compute new value from operand op and old value: RW -> op; RS -> old|op; RC -> old&~op; committed on the accept edge only when req_write_enable=1.
REQ-026 SHALL capture resp_rdata as the pre-write value when req_read_enable=1, else 0.
REQ-027 SHALL increment mcycle by 1 every cycle after reset, wrapping 2^64-1 -> 0.
REQ-028 SHALL increment minstret by 1 per cycle with retire=1, wrapping likewise.
REQ-029 SHALL let a CSR write to a counter half take priority over that cycle's increment; the other half keeps its pre-write value that cycle (no carry into or out of the written half).
REQ-030 SHALL return counter values as sampled at the accept edge, before that edge's increment.
REQ-031 SHALL use only the low 32 bits of each counter half when XLEN=32; for XLEN=64, low addresses return the full 64 bits and high addresses are illegal.

Reset
REQ-032 SHALL on reset_n=0 immediately force state IDLE, resp_valid=0, resp_rdata=0, resp_illegal=0, all scratch=0, mcycle=0, minstret=0.
REQ-033 SHALL discard any pending response when reset asserts in RESP; nothing is replayed after release.
REQ-034 SHALL start counting mcycle on the first rising edge with reset_n=1.

Verification
REQ-035 SHALL cover: RW to 0x340 op=0xDEADBEEF, read_en=1 after reset -> next cycle resp_valid=1, rdata=0; then RS with uimm=5 -> rdata=0xDEADBEEF, scratch becomes 0xDEADBEEF.
REQ-036 SHALL cover: RC op=0x0000FFFF on scratch=0xDEADBEEF -> scratch=0xDEAD0000; RS with write_en=0 -> scratch unchanged.
REQ-037 SHALL cover: write 0xC00, write_en=1 -> resp_illegal=1, rdata=0, counters unaffected; read 0x7FF -> illegal.
REQ-038 SHALL cover: RW 0xB00 op=0xFFFFFFFF, then read 0xB80 two cycles later -> 0x00000001 (carry from wrap).
REQ-039 SHALL cover: resp_ready held 0 for 5 cycles -> resp fields stable, req_ready=0 throughout, retire pulses still counted in minstret.
REQ-040 SHALL cover: reset_n pulsed low in RESP -> resp_valid=0 asynchronously, scratch=0, mcycle restarts at 0.
